line_beat_buffer: RTL and testbench

Parametrised cache-line buffer between the cache data array and the AXI beat interface, replacing the single-shift-register approach with explicit fill and drain engines. FILL assembles a full line from valid/ready-handshaked AXI read beats. DRAIN streams a line out as handshaked AXI write beats, rotating the register so the line is preserved. A beat counter, last-beat checking, abort, and done pulses let the cache FSM sequence refills and write-backs without counting beats itself.

---
 rtl/line_beat_buffer.sv | 116 +++++++++++
 tb/tb_line_beat_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/line_beat_buffer.sv
// line_beat_buffer: cache-line register with AXI-beat fill and rotating drain engines.
module line_beat_buffer #(
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int BLOCK_WIDTH    = 512,
  localparam int BEAT_COUNT     = BLOCK_WIDTH / AXI_DATA_WIDTH,
  localparam int CNT_WIDTH      = $clog2(BEAT_COUNT)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_load_en,
  input  logic [BLOCK_WIDTH-1:0]    i_block,
  input  logic                      i_start_fill,
  input  logic                      i_start_drain,
  input  logic                      i_abort,
  input  logic [AXI_DATA_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [BLOCK_WIDTH-1:0]    o_block,
  output logic [CNT_WIDTH-1:0]      o_beat_cnt,
  output logic                      o_busy,
  output logic                      o_fill_done,
  output logic                      o_drain_done,
  output logic                      o_err
);
  localparam int D = AXI_DATA_WIDTH;
  localparam int W = BLOCK_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BEAT_COUNT - 1);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;
  state_e         state_q, state_d;
  logic [W-1:0]   block_q, block_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic           err_q, err_d, fill_done_q, fill_done_d, drain_done_q, drain_done_d;
  logic           at_last;
  assign at_last      = cnt_q == LAST;
  assign s_ready      = state_q == FILL;
  assign m_valid      = state_q == DRAIN;
  assign m_data       = block_q[D-1:0];
  assign m_last       = m_valid && at_last;
  assign o_block      = block_q;
  assign o_beat_cnt   = cnt_q;
  assign o_busy       = state_q != IDLE;
  assign o_fill_done  = fill_done_q;
  assign o_drain_done = drain_done_q;
  assign o_err        = err_q;
  always_comb begin
    state_d      = state_q;
    block_d      = block_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fill_done_d  = 1'b0;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start_fill) begin
          state_d = FILL;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          block_d = i_load_en ? i_block : block_q;
          if (i_start_drain) begin
            state_d = DRAIN;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      FILL: begin
        if (i_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_valid) begin
          block_d = {s_data, block_q[W-1:D]};
          err_d   = err_q | (s_last != at_last);
          cnt_d   = at_last ? '0 : cnt_q + CNT_WIDTH'(1);
          state_d = at_last ? IDLE : FILL;
          fill_done_d = at_last;
        end
      end
      DRAIN: begin
        if (i_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (m_ready) begin
          // rotate so the line is intact once every beat has gone out
          block_d = {block_q[D-1:0], block_q[W-1:D]};
          cnt_d   = at_last ? '0 : cnt_q + CNT_WIDTH'(1);
          state_d = at_last ? IDLE : DRAIN;
          drain_done_d = at_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= IDLE;
      block_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      block_q      <= block_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fill_done_q  <= fill_done_d;
      drain_done_q <= drain_done_d;
    end
  end
endmodule

// File: tb/tb_line_beat_buffer.sv
// tb_line_beat_buffer: directed checks of fill, drain, reset, error and collision behaviour.
module tb_line_beat_buffer;
  logic         clk = 1'b0;
  logic         arst, i_load_en, i_start_fill, i_start_drain, i_abort;
  logic [511:0] i_block, o_block, line;
  logic [31:0]  s_data, m_data;
  logic         s_valid, s_last, s_ready, m_valid, m_last, m_ready;
  logic [3:0]   o_beat_cnt;
  logic         o_busy, o_fill_done, o_drain_done, o_err;
  int           n_checks = 0, n_fails = 0;

  line_beat_buffer dut (
    .clk(clk), .arst(arst), .i_load_en(i_load_en), .i_block(i_block),
    .i_start_fill(i_start_fill), .i_start_drain(i_start_drain), .i_abort(i_abort),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .o_block(o_block), .o_beat_cnt(o_beat_cnt), .o_busy(o_busy),
    .o_fill_done(o_fill_done), .o_drain_done(o_drain_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_beat(input logic [31:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    arst = 1'b1; i_load_en = 0; i_block = '0; i_start_fill = 0; i_start_drain = 0;
    i_abort = 0; s_data = '0; s_valid = 0; s_last = 0; m_ready = 0;
    step(); step();
    arst = 1'b0;
    check("rst_block", o_block, '0);
    check("rst_busy", o_busy, 0);
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);

    // reset asserted mid-drain
    for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'h1000 + k;
    i_block = line; i_load_en = 1; i_start_drain = 1; step();
    i_load_en = 0; i_start_drain = 0; m_ready = 1;
    step(); step();
    check("mid_drain_cnt", o_beat_cnt, 2);
    arst = 1; step(); step(); arst = 0; m_ready = 0;
    check("rst2_block", o_block, '0);
    check("rst2_cnt", o_beat_cnt, 0);
    check("rst2_mvalid", m_valid, 0);
    check("rst2_busy", o_busy, 0);
    check("rst2_err", o_err, 0);

    // a reset pulse that sees no clock edge changes nothing
    i_load_en = 1; step(); i_load_en = 0;
    arst = 1; #2; arst = 0; #1;
    check("glitch_block", o_block, line);
    step();
    check("glitch_block2", o_block, line);

    // plain fill of beats 0..15
    i_start_fill = 1; step(); i_start_fill = 0;
    check("fill_sready", s_ready, 1);
    for (int k = 0; k < 16; k++) begin
      check("fill_done_early", o_fill_done, 0);
      fill_beat(k, k == 15);
    end
    check("fill_done", o_fill_done, 1);
    check("fill_busy", o_busy, 0);
    check("fill_err", o_err, 0);
    for (int k = 0; k < 16; k++) check($sformatf("fill_w%0d", k), o_block[32*k +: 32], k);
    step();
    check("fill_done_once", o_fill_done, 0);

    // drain with alternating backpressure, starting stalled
    for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'hA0 + k;
    begin
      int c = 0, idx = 0;
      i_block = line; i_load_en = 1; step(); i_load_en = 0;
      i_start_drain = 1; step(); i_start_drain = 0;
      while (o_busy && c < 64) begin
        m_ready = c[0];
        check("drain_data", m_data, 32'hA0 + idx);
        check("drain_last", m_last, idx == 15);
        step();
        if (m_ready) idx++;
        c++;
      end
      m_ready = 0;
      check("drain_cycles", c, 32);
      check("drain_beats", idx, 16);
      check("drain_done", o_drain_done, 1);
      check("drain_line", o_block, line);
      step();
      check("drain_done_once", o_drain_done, 0);
    end

    // early s_last raises a sticky error but the fill still runs to 16 beats
    i_start_fill = 1; step(); i_start_fill = 0;
    for (int k = 0; k < 16; k++) begin
      fill_beat(32'h20 + k, k == 7);
      if (k == 7) check("err_set", o_err, 1);
    end
    check("err_fill_done", o_fill_done, 1);
    check("err_sticky", o_err, 1);
    i_start_fill = 1; step(); i_start_fill = 0;
    check("err_cleared", o_err, 0);
    i_abort = 1; step(); i_abort = 0;
    check("abort_idle", o_busy, 0);

    // start collision, ignored drain during fill, abort at beat 4
    i_start_fill = 1; i_start_drain = 1; step(); i_start_fill = 0; i_start_drain = 0;
    check("coll_fill", s_ready, 1);
    check("coll_no_drain", m_valid, 0);
    fill_beat(32'h30, 0);
    fill_beat(32'h31, 0);
    i_start_drain = 1; fill_beat(32'h32, 0); i_start_drain = 0;
    check("drain_ignored", m_valid, 0);
    check("cnt3", o_beat_cnt, 3);
    fill_beat(32'h33, 0);
    i_abort = 1; fill_beat(32'h34, 0); i_abort = 0;
    check("abort_busy", o_busy, 0);
    check("abort_cnt", o_beat_cnt, 0);
    check("abort_no_done", o_fill_done, 0);
    for (int k = 0; k < 4; k++) check($sformatf("abort_w%0d", 12 + k), o_block[32*(12+k) +: 32], 32'h30 + k);
    step();
    check("abort_no_done2", o_fill_done, 0);

    // load and drain in the same cycle sends the new line
    for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'h5A00_0000 + k;
    i_block = line; i_load_en = 1; i_start_drain = 1; step();
    i_load_en = 0; i_start_drain = 0;
    check("ld_drain_valid", m_valid, 1);
    check("ld_drain_first", m_data, 32'h5A00_0000);
    m_ready = 1;
    begin
      int c = 0;
      while (o_busy && c < 40) begin step(); c++; end
      check("ld_drain_cycles", c, 16);
    end
    m_ready = 0;
    check("ld_drain_done", o_drain_done, 1);
    check("ld_drain_line", o_block, line);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
